// File: rtl/fetch_redirect_ctrl.sv
// Fetch sequencer: owns the fetch PC, keeps one IMEM request in flight, applies redirects
// and drops stale responses. Optional counters are enabled with the FETCH_STATS_EN define.

`ifndef size_X_LEN
`define size_X_LEN 32
`endif

module fetch_redirect_ctrl #(
    parameter int XLEN = `size_X_LEN
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            enable_design,
    input  logic [XLEN-1:0] initial_pc_i,
    input  logic            jump_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] target_pc_i,
    input  logic            irq_prep_i,
    input  logic [XLEN-1:0] interrupt_vector_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [31:0]     if_instr_o,
    input  logic            if_ready_i,
`ifdef FETCH_STATS_EN
    output logic [31:0]     stat_redirects_o,
    output logic [31:0]     stat_discards_o,
`endif
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } if_slot_t;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            stale_q, stale_d;
    if_slot_t        slot_q, slot_d;

    logic            redir;
    logic [XLEN-1:0] redir_pc;

    // Fixed priority: mret beats interrupt entry beats jump/branch.
    assign redir    = mret_i | irq_prep_i | jump_i | branch_i;
    assign redir_pc = mret_i     ? mepc_i :
                      irq_prep_i ? interrupt_vector_i :
                                   target_pc_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_BOOT;
            pc_q    <= '0;
            stale_q <= 1'b0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
            slot_q  <= slot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stale_d = stale_q;
        slot_d  = slot_q;
        if (enable_design) begin
            unique case (state_q)
                S_BOOT: begin
                    pc_d    = initial_pc_i;
                    state_d = S_REQ;
                end
                S_REQ: begin
                    if (redir) pc_d = redir_pc;
                    // A request accepted alongside a redirect carried the old PC.
                    if (imem_req_ready_i) begin
                        state_d = S_WAIT;
                        stale_d = redir;
                    end
                end
                S_WAIT: begin
                    if (redir) pc_d = redir_pc;
                    if (!imem_rsp_valid_i) begin
                        if (redir) stale_d = 1'b1;
                    end else if (stale_q || redir) begin
                        stale_d = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        stale_d      = 1'b0;
                        slot_d.pc    = pc_q;
                        slot_d.instr = imem_rsp_data_i;
                        state_d      = S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Redirect wins over consume; the held instruction is dropped.
                    if (redir) begin
                        pc_d    = redir_pc;
                        state_d = S_REQ;
                    end else if (if_ready_i) begin
                        pc_d    = pc_q + XLEN'(4);
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_BOOT;
            endcase
        end
    end

    assign imem_req_valid_o = enable_design && (state_q == S_REQ);
    assign imem_req_addr_o  = pc_q;
    assign if_valid_o       = (state_q == S_HOLD);
    assign if_pc_o          = slot_q.pc;
    assign if_instr_o       = slot_q.instr;
    assign state_o          = state_q;

`ifdef FETCH_STATS_EN
    logic        redir_take;
    logic        discard;
    logic [31:0] redirects_q;
    logic [31:0] discards_q;

    assign redir_take = enable_design && redir && (state_q != S_BOOT);
    assign discard    = enable_design && (state_q == S_WAIT) && imem_rsp_valid_i &&
                        (stale_q || redir);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            redirects_q <= '0;
            discards_q  <= '0;
        end else begin
            if (redir_take) redirects_q <= redirects_q + 32'd1;
            if (discard)    discards_q  <= discards_q + 32'd1;
        end
    end

    assign stat_redirects_o = redirects_q;
    assign stat_discards_o  = discards_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios plus random traffic against a
// rule-level model; an IMEM responder with configurable latency lives in the bench.

module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [31:0] init_pc = '0, tgt = '0, vec = '0, mepc = '0;
    logic        jump = 1'b0, branch = 1'b0, irq = 1'b0, mret = 1'b0;
    logic        req_ready = 1'b0, if_ready = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic [1:0]  state_o;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_redirects_o;
    logic [31:0] stat_discards_o;
`endif

    fetch_redirect_ctrl #(.XLEN(32)) dut (
        .clk_i              (clk),
        .reset_i            (rst),
        .enable_design      (en),
        .initial_pc_i       (init_pc),
        .jump_i             (jump),
        .branch_i           (branch),
        .target_pc_i        (tgt),
        .irq_prep_i         (irq),
        .interrupt_vector_i (vec),
        .mret_i             (mret),
        .mepc_i             (mepc),
        .imem_req_valid_o   (imem_req_valid_o),
        .imem_req_addr_o    (imem_req_addr_o),
        .imem_req_ready_i   (req_ready),
        .imem_rsp_valid_i   (rsp_valid),
        .imem_rsp_data_i    (rsp_data),
        .if_valid_o         (if_valid_o),
        .if_pc_o            (if_pc_o),
        .if_instr_o         (if_instr_o),
        .if_ready_i         (if_ready),
`ifdef FETCH_STATS_EN
        .stat_redirects_o   (stat_redirects_o),
        .stat_discards_o    (stat_discards_o),
`endif
        .state_o            (state_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // ---------------- IMEM responder ----------------
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    logic        lat_rand = 1'b0;
    int          lat_fixed = 1;
    logic        spur_mode = 1'b0;
    logic        spur_en = 1'b0;
    logic [31:0] spur_data = '0;
    int          cyc = 0;
    logic [31:0] acc_q[$];
    int          acc_cyc[$];
    logic [31:0] cons_q[$];
    int          acc_base = 0, cons_base = 0;

    logic        rd;
    logic [31:0] rtgt;
    assign rd   = mret | irq | jump | branch;
    assign rtgt = mret ? mepc : irq ? vec : tgt;

    logic [1:0]  m_state;
    logic [31:0] m_pc, m_ifpc, m_ifins, m_nred, m_ndis;
    logic        m_stale;

    assign rsp_valid = (pend && cnt == 0) || (spur_en && m_state != 2'd2);
    assign rsp_data  = pend ? imem_word(paddr) : spur_data;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_req_valid_o && req_ready) begin
            pend  <= 1'b1;
            cnt   <= lat_rand ? $urandom_range(0, 2) : lat_fixed - 1;
            paddr <= imem_req_addr_o;
            acc_q.push_back(imem_req_addr_o);
            acc_cyc.push_back(cyc);
        end else if (pend) begin
            if (cnt != 0) cnt <= cnt - 1;
            else if (en || m_state != 2'd2) pend <= 1'b0;
        end
        if (en && if_valid_o && if_ready && !rd) cons_q.push_back(if_pc_o);
        spur_en   <= spur_mode && ($urandom_range(0, 7) == 0);
        spur_data <= $urandom;
    end

    // ---------------- behavioural model ----------------
    // 0 boot, 1 request, 2 wait for response, 3 holding an instruction for IF.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 2'd0; m_pc <= '0; m_stale <= 1'b0;
            m_ifpc <= '0; m_ifins <= '0; m_nred <= '0; m_ndis <= '0;
        end else if (en) begin
            if (m_state != 2'd0 && rd) m_nred <= m_nred + 1;
            case (m_state)
                2'd0: begin m_pc <= init_pc; m_state <= 2'd1; end
                2'd1: begin
                    if (rd) m_pc <= rtgt;
                    if (req_ready) begin m_state <= 2'd2; m_stale <= rd; end
                end
                2'd2: begin
                    if (rd) m_pc <= rtgt;
                    if (!rsp_valid) begin
                        if (rd) m_stale <= 1'b1;
                    end else if (m_stale || rd) begin
                        m_ndis <= m_ndis + 1; m_stale <= 1'b0; m_state <= 2'd1;
                    end else begin
                        m_ifpc <= m_pc; m_ifins <= rsp_data; m_stale <= 1'b0; m_state <= 2'd3;
                    end
                end
                default: begin
                    if (rd) begin m_pc <= rtgt; m_state <= 2'd1; end
                    else if (if_ready) begin m_pc <= m_pc + 32'd4; m_state <= 2'd1; end
                end
            endcase
        end
    end

    logic chk_on = 1'b0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("state", 32'(state_o), 32'(m_state));
            chk("req_valid", 32'(imem_req_valid_o), 32'(m_state == 2'd1 && en));
            chk("req_addr", imem_req_addr_o, m_pc);
            chk("if_valid", 32'(if_valid_o), 32'(m_state == 2'd3));
            chk("if_pc", if_pc_o, m_ifpc);
            chk("if_instr", if_instr_o, m_ifins);
`ifdef FETCH_STATS_EN
            chk("stat_redirects", stat_redirects_o, m_nred);
            chk("stat_discards", stat_discards_o, m_ndis);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_redir();
        jump = 0; branch = 0; irq = 0; mret = 0; tgt = '0; vec = '0; mepc = '0;
    endtask

    task automatic do_reset();
        en = 0; clear_redir();
        rst = 1; step(); step(); rst = 0;
        acc_base = acc_q.size(); cons_base = cons_q.size();
    endtask

    function automatic int nacc();
        return acc_q.size() - acc_base;
    endfunction

    task automatic wait_acc(input int n);
        int k = 0;
        while (nacc() < n && k < 50) begin step(); k++; end
        chk("accept_timeout", 32'(nacc() >= n), 32'd1);
    endtask

    task automatic wait_ifvalid();
        int k = 0;
        while (!if_valid_o && k < 50) begin step(); k++; end
        chk("ifvalid_timeout", 32'(if_valid_o), 32'd1);
    endtask

    initial begin
        // Reset values
        #1 rst = 1; step(); step(); rst = 0;
        chk_on = 1;
        @(negedge clk);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("rst_addr", imem_req_addr_o, 32'd0);
        chk("rst_if_valid", 32'(if_valid_o), 32'd0);
        chk("rst_if_pc", if_pc_o, 32'd0);
        chk("rst_if_instr", if_instr_o, 32'd0);

        // Boot stream with a 1-cycle IMEM and an always-ready IF stage
        init_pc = 32'h0000_1000; lat_fixed = 1; req_ready = 1; if_ready = 1; en = 1;
        step();
        @(negedge clk);
        chk("boot_req_valid", 32'(imem_req_valid_o), 32'd1);
        chk("boot_addr", imem_req_addr_o, 32'h1000);
        wait_acc(4);
        chk("fetch0", acc_q[acc_base], 32'h1000);
        chk("fetch1", acc_q[acc_base+1], 32'h1004);
        chk("fetch2", acc_q[acc_base+2], 32'h1008);
        chk("if_pc0", cons_q[cons_base], 32'h1000);
        chk("if_pc1", cons_q[cons_base+1], 32'h1004);
        chk("cycles_per_instr", 32'(acc_cyc[acc_base+1] - acc_cyc[acc_base]), 32'd3);

        // Branch while the 0x1000 response is in flight
        do_reset();
`ifdef FETCH_STATS_EN
        @(negedge clk);
        chk("stat_red_rst", stat_redirects_o, 32'd0);
        chk("stat_dis_rst", stat_discards_o, 32'd0);
`endif
        init_pc = 32'h1000; en = 1; req_ready = 1; if_ready = 1;
        wait_acc(1);
        branch = 1; tgt = 32'h2000;
        step();
        clear_redir();
        @(negedge clk);
        chk("wait_redir_ifvalid", 32'(if_valid_o), 32'd0);
        chk("wait_redir_addr", imem_req_addr_o, 32'h2000);
        wait_acc(2);
        chk("wait_redir_fetch", acc_q[acc_base+1], 32'h2000);
        chk("wait_redir_nocons", 32'(cons_q.size() - cons_base), 32'd0);
`ifdef FETCH_STATS_EN
        @(negedge clk);
        chk("stat_red_one", stat_redirects_o, 32'd1);
        chk("stat_dis_one", stat_discards_o, 32'd1);
`endif

        // Simultaneous redirect priority while held in REQ
        do_reset();
        en = 1; req_ready = 0;
        step();
        mret = 1; irq = 1; jump = 1; mepc = 32'h3000; vec = 32'h0100; tgt = 32'h4000;
        step();
        @(negedge clk);
        chk("prio_mret", imem_req_addr_o, 32'h3000);
        mret = 0;
        step();
        @(negedge clk);
        chk("prio_irq", imem_req_addr_o, 32'h0100);
        clear_redir();

        // Redirect beats consume in HOLD
        do_reset();
        init_pc = 32'h1000; en = 1; req_ready = 1; if_ready = 1;
        wait_acc(2);
        if_ready = 0;
        wait_ifvalid();
        chk("hold_pc", if_pc_o, 32'h1004);
        jump = 1; tgt = 32'h5000; if_ready = 1;
        step();
        clear_redir();
        @(negedge clk);
        chk("hold_redir_ifvalid", 32'(if_valid_o), 32'd0);
        chk("hold_redir_addr", imem_req_addr_o, 32'h5000);
        wait_acc(3);
        chk("hold_redir_fetch", acc_q[acc_base+2], 32'h5000);
        chk("hold_redir_cons", 32'(cons_q.size() - cons_base), 32'd1);

        // PC wrap, request backpressure, enable freeze in HOLD
        do_reset();
        init_pc = 32'hFFFF_FFFC; en = 1; req_ready = 1; if_ready = 1;
        wait_acc(1);
        req_ready = 0;
        for (int k = 0; k < 20 && state_o != 2'd1; k++) step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_addr", imem_req_addr_o, 32'h0);
            chk("bp_valid", 32'(imem_req_valid_o), 32'd1);
            step();
        end
        req_ready = 1;
        wait_acc(2);
        chk("wrap_fetch", acc_q[acc_base+1], 32'h0);
        if_ready = 0;
        wait_ifvalid();
        en = 0; if_ready = 1; jump = 1; tgt = 32'h7000;
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            chk("frz_ifvalid", 32'(if_valid_o), 32'd1);
            chk("frz_state", 32'(state_o), 32'd3);
            chk("frz_reqv", 32'(imem_req_valid_o), 32'd0);
            chk("frz_pc", if_pc_o, 32'h0);
            chk("frz_instr", if_instr_o, imem_word(32'h0));
        end
        en = 1; clear_redir();
        step();
        @(negedge clk);
        chk("unfreeze_addr", imem_req_addr_o, 32'h4);

        // Asynchronous reset while waiting, with the response arriving afterwards
        do_reset();
        init_pc = 32'h1000; en = 1; req_ready = 1; if_ready = 1; lat_fixed = 3;
        wait_acc(1);
        #2 rst = 1;
        #2 chk("arst_state", 32'(state_o), 32'd0);
        #2 rst = 0; en = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            chk("arst_boot", 32'(state_o), 32'd0);
            chk("arst_ifvalid", 32'(if_valid_o), 32'd0);
        end
`ifdef FETCH_STATS_EN
        chk("arst_stat_red", stat_redirects_o, 32'd0);
        chk("arst_stat_dis", stat_discards_o, 32'd0);
`endif
        lat_fixed = 1;

        // Random traffic checked every cycle against the model
        do_reset();
        init_pc = $urandom & 32'hFFFF_FFFC;
        lat_rand = 1; spur_mode = 1;
        for (int k = 0; k < 3000; k++) begin
            step();
            en        = ($urandom_range(0, 9) != 0);
            mret      = ($urandom_range(0, 24) == 0);
            irq       = ($urandom_range(0, 19) == 0);
            jump      = ($urandom_range(0, 14) == 0);
            branch    = ($urandom_range(0, 14) == 0);
            tgt       = $urandom & 32'hFFFF_FFFC;
            vec       = $urandom & 32'hFFFF_FFFC;
            mepc      = $urandom & 32'hFFFF_FFFC;
            req_ready = ($urandom_range(0, 9) < 7);
            if_ready  = ($urandom_range(0, 9) < 6);
        end
        chk("rand_progress", 32'(cons_q.size() - cons_base > 50), 32'd1);
        clear_redir(); spur_mode = 0;
        step();
        @(negedge clk);
        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Fetch sequencer between the PC logic and instruction memory. It owns the architectural fetch PC and issues one outstanding request at a time to IMEM. It arbitrates redirect sources (mret, interrupt, jump/branch) and discards responses made stale by a redirect. Accepted instructions are presented to the IF stage over a valid/ready handshake.

## Interface
- `XLEN`, default `size_X_LEN` (32): address/data width.
- `clk_i` in 1: clock, rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `enable_design` in 1: global run enable. Low freezes all state.
- `initial_pc_i` in XLEN: boot PC, sampled in BOOT.
- `jump_i`, `branch_i` in 1: taken control-flow redirect to `target_pc_i`.
- `target_pc_i` in XLEN: jump/branch target.
- `irq_prep_i` in 1: interrupt entry redirect to `interrupt_vector_i`.
- `interrupt_vector_i` in XLEN: trap vector.
- `mret_i` in 1: return redirect to `mepc_i`.
- `mepc_i` in XLEN: return address.
- `imem_req_valid_o` out 1: fetch request valid.
- `imem_req_addr_o` out XLEN: fetch address (current PC).
- `imem_req_ready_i` in 1: IMEM accepts request.
- `imem_rsp_valid_i` in 1: IMEM returns data, ≥1 cycle after acceptance.
- `imem_rsp_data_i` in 32: instruction word.
- `if_valid_o` out 1: instruction held for IF.
- `if_pc_o` out XLEN: PC of held instruction.
- `if_instr_o` out 32: held instruction.
- `if_ready_i` in 1: IF consumes instruction.
- `state_o` out 2: current state (BOOT=0, REQ=1, WAIT=2, HOLD=3).

## Operation
- Redirect select, highest first: `mret_i`→`mepc_i`; `irq_prep_i`→`interrupt_vector_i`; `jump_i|branch_i`→`target_pc_i`. Any redirect is called `redir`.
- BOOT: on the first cycle with `enable_design`, load PC←`initial_pc_i` and go to REQ. Redirects are ignored in BOOT.
- REQ: `imem_req_valid_o`=`enable_design`, address=PC.
  - Handshake, no `redir`: go to WAIT, stale=0.
  - Handshake with `redir`: PC←redirect target, go to WAIT, stale=1. The accepted request carried the old PC.
  - No handshake with `redir`: PC←target, remain in REQ. The new address appears next cycle.
- WAIT: wait for `imem_rsp_valid_i`.
  - `redir` before the response: PC←target, stale←1.
  - Response with stale=1, or response in the same cycle as `redir`: discard it, go to REQ with the current/new PC.
  - Otherwise: capture `if_instr_o`←data and `if_pc_o`←PC, go to HOLD.
- HOLD: `if_valid_o`=1.
  - `if_ready_i` without `redir`: PC←PC+4 (modulo 2^XLEN), go to REQ.
  - `redir`: drop the held instruction (`if_valid_o` low next cycle), PC←target, go to REQ.
- `redir` takes priority over `if_ready_i` in the same cycle. The instruction is not counted as consumed.
- `imem_rsp_valid_i` outside WAIT is ignored.
- `enable_design`=0: no state, PC, or stale update. `imem_req_valid_o`=0. `if_valid_o` holds its value.

## Timing
- Reset values: state BOOT, PC 0, stale 0, `imem_req_valid_o` 0, `imem_req_addr_o` 0, `if_valid_o` 0, `if_pc_o` 0, `if_instr_o` 0.
- Release from reset: BOOT→REQ in 1 enabled cycle. The first request is visible in the following cycle.
- Nominal loop with 1-cycle IMEM and `if_ready_i`=1: REQ(accept)→WAIT(rsp)→HOLD(consume)→REQ. That is 3 cycles per instruction.
- Redirect-to-request latency: 1 cycle. The new address appears on `imem_req_addr_o` the cycle after `redir`.
- At most one request outstanding. A stale response costs exactly one extra WAIT cycle.
- Reset mid-WAIT: the state machine returns to BOOT immediately. A late response afterwards is ignored because the state is not WAIT.

## Configuration
- `FETCH_STATS_EN`, when defined, adds two counters:
  - `stat_redirects_o` out 32: incremented per accepted `redir` outside BOOT.
  - `stat_discards_o` out 32: incremented per discarded response.
  - Both wrap, reset to 0, and freeze when `enable_design`=0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Boot: `initial_pc_i`=0x0000_1000, 1-cycle IMEM, `if_ready_i`=1 → fetch addresses 0x1000, 0x1004, 0x1008. `if_pc_o` matches each and the instruction returns in order.
- Redirect in WAIT: request 0x1000 accepted, `branch_i` with target 0x2000 the next cycle → response for 0x1000 is discarded (no `if_valid_o`), next request is 0x2000.
- Simultaneous redirects: `mret_i`, `irq_prep_i` and `jump_i` in one cycle with mepc 0x3000, vector 0x0100, target 0x4000 → next request 0x3000. Repeat without `mret_i` → 0x0100.
- HOLD redirect vs consume: `if_valid_o`=1 for PC 0x1004, `if_ready_i`=1 and `jump_i` (0x5000) same cycle → `if_valid_o` drops, next request is 0x5000, not 0x1008.
- Backpressure and wrap: PC 0xFFFF_FFFC consumed → next request 0x0000_0000. `imem_req_ready_i` low for 4 cycles → address held stable. `enable_design` low 3 cycles in HOLD → outputs frozen.
- Async reset in WAIT, then response arrives → state BOOT, response ignored. With `FETCH_STATS_EN`, the counters read 0 after reset and count 1 redirect and 1 discard in the WAIT-redirect scenario.
